// File: rtl/audio_feed_pio_key.sv
// rtl/audio_feed_pio_key.sv - input PIO: sync, debounce, edge capture, maskable level irq
module audio_feed_pio_key #(
   parameter int WIDTH     = 4,
   parameter int DEBOUNCE  = 16,
   parameter int EDGE_TYPE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
   // Active-low keys idle high, so the debounced value starts high to avoid a false edge.
   localparam logic [WIDTH-1:0] STABLE_RST = (EDGE_TYPE == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   logic [WIDTH-1:0] sync1, sync2, stable, prev;
   logic [WIDTH-1:0] edge_event, edge_capture, irq_mask, w1c;
   logic [31:0]      rd_mux;
   logic             wr_en, rd_en;

   assign wr_en = chipselect & ~write_n;
   assign rd_en = chipselect & ~read_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   generate
      if (DEBOUNCE == 0) begin : g_bypass
         always_ff @(posedge clk) begin
            if (reset) stable <= STABLE_RST;
            else       stable <= sync2;
         end
      end else begin : g_debounce
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [CW-1:0] cnt;
            logic          st;
            always_ff @(posedge clk) begin
               if (reset) begin
                  cnt <= '0;
                  st  <= STABLE_RST[i];
               end else if (sync2[i] == st) begin
                  cnt <= '0;
               end else if (cnt == CW'(DEBOUNCE - 1)) begin
                  st  <= sync2[i];
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            assign stable[i] = st;
         end
      end
   endgenerate

   always_comb begin
      edge_event = stable ^ prev;
      case (EDGE_TYPE)
         0:       edge_event = stable & ~prev;
         1:       edge_event = ~stable & prev;
         default: edge_event = stable ^ prev;
      endcase
   end

   assign w1c = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // A new event outranks a simultaneous W1C so no press is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev         <= '0;
         edge_capture <= '0;
         irq_mask     <= '0;
      end else begin
         prev         <= stable;
         edge_capture <= (edge_capture & ~w1c) | edge_event;
         if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux[WIDTH-1:0] = stable;
         2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
         2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)      readdata <= '0;
      else if (rd_en) readdata <= rd_mux;
      else            readdata <= '0;
   end

   assign irq = |(edge_capture & irq_mask);

   generate
      if (WIDTH < 32) begin : g_unused
         logic unused_wd;
         assign unused_wd = ^writedata[31:WIDTH];
      end
   endgenerate

endmodule

// File: tb/tb_audio_feed_pio_key.sv
// tb/tb_audio_feed_pio_key.sv - scoreboard bench for audio_feed_pio_key
module tb_audio_feed_pio_key;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [3:0]  in_port = 4'hF;
   logic [31:0] readdata;
   logic        irq;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_entry_t;

   sb_entry_t   sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic        mon_rd;
   sb_entry_t   mon_e;

   audio_feed_pio_key #(.WIDTH(4), .DEBOUNCE(16), .EDGE_TYPE(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      sb_entry_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
      address    = a;
      chipselect = 1'b1;
      read_n     = 1'b0;
      tick(1);
      chipselect = 1'b0;
      read_n     = 1'b1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // Read data appears one cycle after the strobe is sampled.
   always @(posedge clk) begin
      mon_rd = chipselect && !read_n;
      #1;
      if (mon_rd) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, readdata, mon_e.exp);
         end
      end
   end

   initial begin
      // reset with idle-high keys
      tick(2);
      reset = 1'b0;
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'h0);
      rd("rst_data", 2'd0, 32'hF);
      rd("rst_edge", 2'd3, 32'h0);

      // short glitch discarded
      in_port = 4'hE;
      for (int k = 1; k <= 10; k++) rd("glitch_data", 2'd0, 32'hF);
      in_port = 4'hF;
      for (int k = 1; k <= 20; k++) rd("glitch_data2", 2'd0, 32'hF);
      rd("glitch_edge", 2'd3, 32'h0);

      // held press accepted exactly 2+16 cycles after the change
      in_port = 4'hE;
      for (int k = 1; k <= 20; k++) rd("deb_data", 2'd0, (k >= 19) ? 32'hE : 32'hF);
      in_port = 4'hF;
      rd("deb_edge", 2'd3, 32'h1);
      tick(20);
      wr(2'd3, 32'h1);
      chk("irq_unmasked", {31'd0, irq}, 32'h0);

      // irq behaviour
      wr(2'd2, 32'h1);
      in_port = 4'hE;
      tick(20);
      chk("irq_press", {31'd0, irq}, 32'h1);
      in_port = 4'hF;
      tick(20);
      chk("irq_held", {31'd0, irq}, 32'h1);
      wr(2'd3, 32'h1);
      chk("irq_w1c", {31'd0, irq}, 32'h0);
      in_port = 4'hE;
      tick(20);
      chk("irq_press2", {31'd0, irq}, 32'h1);
      wr(2'd2, 32'h0);
      chk("irq_masked", {31'd0, irq}, 32'h0);
      rd("edge_kept", 2'd3, 32'h1);
      wr(2'd3, 32'h1);
      in_port = 4'hF;
      tick(20);

      // event and W1C in the same cycle: set wins
      in_port = 4'hB;
      tick(18);
      wr(2'd3, 32'h4);
      rd("collision", 2'd3, 32'h4);
      in_port = 4'hF;
      tick(20);

      // register map and read timing
      wr(2'd2, 32'hA);
      chk("rd_idle_pre", readdata, 32'h0);
      rd("mask_rd", 2'd2, 32'hA);
      tick(1);
      chk("rd_idle_post", readdata, 32'h0);
      rd("addr1_rd", 2'd1, 32'h0);
      wr(2'd1, 32'hFFFF_FFFF);
      rd("addr1_rd2", 2'd1, 32'h0);
      wr(2'd0, 32'h5);
      rd("data_ro", 2'd0, 32'hF);
      wr(2'd2, 32'hFFFF_FFF5);
      rd("mask_trunc", 2'd2, 32'h5);
      wr(2'd2, 32'hA);

      // reset during a pending change
      in_port = 4'hE;
      tick(10);
      reset = 1'b1;
      rd("rst_midread", 2'd0, 32'h0);
      reset = 1'b0;
      rd("rst_mask", 2'd2, 32'h0);
      rd("rst_edge2", 2'd3, 32'h0);
      for (int j = 3; j <= 20; j++) rd("rst_deb", 2'd0, (j >= 17) ? 32'hE : 32'hF);
      in_port = 4'hF;

      tick(2);
      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
